// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master byte engines: FSM states, bit-slot timing and sample-vote codes.
package i2c_pkg;

    localparam int unsigned PHASES_PER_BIT     = 8;
    localparam int unsigned SCL_HIGH_PHASE     = 4;
    localparam int unsigned SDA_UPDATE_PHASE   = 1;
    localparam int unsigned SAMPLE_FIRST_PHASE = 5;
    localparam int unsigned BITS_PER_BYTE      = 8;
    localparam int unsigned PHASE_W            = 3;
    localparam int unsigned BIT_W              = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_ACK,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        VOTE_NONE,
        VOTE_ZERO,
        VOTE_ONE,
        VOTE_UNSTABLE
    } vote_e;

    // Collapse "saw a 0" / "saw a 1" flags into a vote result.
    function automatic vote_e vote(input logic seen0, input logic seen1);
        vote_e v;
        case ({seen1, seen0})
            2'b01:   v = VOTE_ZERO;
            2'b10:   v = VOTE_ONE;
            2'b11:   v = VOTE_UNSTABLE;
            default: v = VOTE_NONE;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/i2c_bit_sampler.sv
// Multi-sample vote of SDA over the SCL-high window; the current sample is folded in combinationally
// so the verdict is available on the same edge that takes the last sample.
module i2c_bit_sampler
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    input  logic sample_i,
    output logic value_c,
    output logic unstable_c
);

    logic  seen0_q, seen1_q;
    logic  seen0_c, seen1_c;
    vote_e vote_c;

    always_comb begin
        seen0_c    = seen0_q | (en_i & ~sample_i);
        seen1_c    = seen1_q | (en_i &  sample_i);
        vote_c     = vote(seen0_c, seen1_c);
        value_c    = (vote_c == VOTE_ONE);
        unstable_c = (vote_c == VOTE_UNSTABLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen0_q <= 1'b0;
            seen1_q <= 1'b0;
        end else if (clear_i) begin
            seen0_q <= 1'b0;
            seen1_q <= 1'b0;
        end else if (en_i) begin
            seen0_q <= seen0_c;
            seen1_q <= seen1_c;
        end
    end

endmodule

// File: rtl/i2c_master_write_byte.sv
// I2C master transmit engine: shifts one byte MSB-first with 8-phase SCL slots, then samples the ACK slot.
// Driven data bits are checked against the bus while SCL is high.
module i2c_master_write_byte
    import i2c_pkg::*;
#(
    parameter bit CHECK_BUS = 1'b1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       go,
    input  logic [7:0] data,
    output logic       finish,
    output logic       ack,
    output logic       error,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       scl
);

    localparam logic [PHASE_W-1:0] LAST_PHASE   = PHASE_W'(PHASES_PER_BIT - 1);
    localparam logic [PHASE_W-1:0] HIGH_PHASE   = PHASE_W'(SCL_HIGH_PHASE);
    localparam logic [PHASE_W-1:0] UPDATE_PHASE = PHASE_W'(SDA_UPDATE_PHASE);
    localparam logic [PHASE_W-1:0] SAMPLE_PHASE = PHASE_W'(SAMPLE_FIRST_PHASE);
    localparam logic [BIT_W-1:0]   LAST_BIT     = BIT_W'(BITS_PER_BYTE - 1);

    state_e             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               scl_q, scl_d;
    logic               sda_q, sda_d;
    logic               finish_q, finish_d;
    logic               ack_q, ack_d;
    logic               error_q, error_d;

    logic smp_value, smp_unstable, smp_en, smp_clear, busy, bit_bad;

    assign busy      = (state_q == ST_SHIFT) || (state_q == ST_ACK);
    assign smp_en    = busy && go && (phase_q >= SAMPLE_PHASE);
    assign smp_clear = (state_q == ST_IDLE) || (phase_q == '0);
    assign bit_bad   = smp_unstable || ((CHECK_BUS != 1'b0) && (smp_value != shift_q[7]));

    i2c_bit_sampler u_sampler (
        .clk        (clock),
        .rst_n      (reset_n),
        .clear_i    (smp_clear),
        .en_i       (smp_en),
        .sample_i   (sda_in),
        .value_c    (smp_value),
        .unstable_c (smp_unstable)
    );

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        scl_d    = scl_q;
        sda_d    = sda_q;
        finish_d = finish_q;
        ack_d    = ack_q;
        error_d  = error_q;

        case (state_q)
            ST_IDLE: begin
                scl_d    = 1'b1;
                sda_d    = 1'b1;
                finish_d = 1'b0;
                if (go) begin
                    shift_d = data;
                    ack_d   = 1'b0;
                    error_d = 1'b0;
                    phase_d = '0;
                    bit_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT, ST_ACK: begin
                if (!go) begin
                    // Abort releases the bus; ack/error keep their last values.
                    state_d  = ST_IDLE;
                    scl_d    = 1'b1;
                    sda_d    = 1'b1;
                    finish_d = 1'b0;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                    scl_d   = (phase_q >= HIGH_PHASE);
                    if (phase_q == UPDATE_PHASE) begin
                        sda_d = (state_q == ST_SHIFT) ? shift_q[7] : 1'b1;
                    end
                    if (phase_q == LAST_PHASE) begin
                        if (state_q == ST_ACK) begin
                            state_d  = ST_DONE;
                            finish_d = 1'b1;
                            sda_d    = 1'b1;
                            ack_d    = ~smp_unstable & ~smp_value;
                            error_d  = smp_unstable;
                        end else if (bit_bad) begin
                            state_d  = ST_DONE;
                            finish_d = 1'b1;
                            sda_d    = 1'b1;
                            error_d  = 1'b1;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            bit_d   = bit_q + BIT_W'(1);
                            if (bit_q == LAST_BIT) begin
                                state_d = ST_ACK;
                            end
                        end
                    end
                end
            end
            ST_DONE: begin
                scl_d = 1'b1;
                sda_d = 1'b1;
                if (!go) begin
                    state_d  = ST_IDLE;
                    finish_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            finish_q <= 1'b0;
            ack_q    <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            scl_q    <= scl_d;
            sda_q    <= sda_d;
            finish_q <= finish_d;
            ack_q    <= ack_d;
            error_q  <= error_d;
        end
    end

    assign scl     = scl_q;
    assign sda_out = sda_q;
    assign finish  = finish_q;
    assign ack     = ack_q;
    assign error   = error_q;

endmodule

// File: tb/tb_i2c_master_write_byte.sv
// Directed bench for i2c_master_write_byte; a second instance with CHECK_BUS=0 runs the same stimulus.
module tb_i2c_master_write_byte;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       go;
    logic [7:0] data;
    logic       sda_in0, sda_out0, scl0, fin0, ack0, err0;
    logic       sda_in1, sda_out1, scl1, fin1, ack1, err1;

    int   n;
    int   test_id;
    logic ack_en;
    logic slave_low, frc_en, frc_val;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // Edge n after start S is seen at the negedge following it; forces apply to the cycle before edge n+1.
    always_comb begin
        frc_en  = 1'b0;
        frc_val = 1'b1;
        if (test_id == 3 && n >= 20 && n <= 23) begin
            frc_en  = 1'b1;
            frc_val = 1'b0;
        end
        if (test_id == 4 && n == 38) begin
            frc_en  = 1'b1;
            frc_val = 1'b1;
        end
    end

    assign slave_low = ack_en && (n >= 66) && (n <= 72);
    assign sda_in0   = frc_en ? frc_val : (sda_out0 & ~slave_low);
    assign sda_in1   = frc_en ? frc_val : (sda_out1 & ~slave_low);

    i2c_master_write_byte #(.CHECK_BUS(1'b1)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .go      (go),
        .data    (data),
        .finish  (fin0),
        .ack     (ack0),
        .error   (err0),
        .sda_in  (sda_in0),
        .sda_out (sda_out0),
        .scl     (scl0)
    );

    i2c_master_write_byte #(.CHECK_BUS(1'b0)) dut_nochk (
        .clock   (clk),
        .reset_n (rst_n),
        .go      (go),
        .data    (data),
        .finish  (fin1),
        .ack     (ack1),
        .error   (err1),
        .sda_in  (sda_in1),
        .sda_out (sda_out1),
        .scl     (scl1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (test %0d, n=%0d)", tag, got, exp, test_id, n);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        n = n + 1;
    endtask

    // Called at a negedge: raise go so the next posedge is the start edge (n becomes 0).
    task automatic start_byte(input logic [7:0] d);
        n    = -1;
        go   = 1'b1;
        data = d;
        step();
    endtask

    task automatic run_full(input logic [7:0] d, input logic exp_ack);
        logic [7:0] obs;
        obs = '0;
        start_byte(d);
        while (n < 72) begin
            step();
            if (n == 1)  check_eq("scl_low_first", 32'(scl0), 32'd0);
            if (n == 5)  check_eq("scl_high_bit0", 32'(scl0), 32'd1);
            if (n < 64 && (n % 8) == 4) obs[7 - (n / 8)] = sda_out0;
            if (n == 71) check_eq("finish_early", 32'(fin0), 32'd0);
        end
        check_eq("finish_s72", 32'(fin0), 32'd1);
        check_eq("ack_s72", 32'(ack0), 32'(exp_ack));
        check_eq("error_s72", 32'(err0), 32'd0);
        check_eq("sda_sequence", 32'(obs), 32'(d));
    endtask

    task automatic end_byte();
        step();
        check_eq("finish_held", 32'(fin0), 32'd1);
        check_eq("scl_done", 32'(scl0), 32'd1);
        go = 1'b0;
        step();
        check_eq("finish_clear", 32'(fin0), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        go      = 1'b0;
        data    = '0;
        test_id = 0;
        ack_en  = 1'b0;
        n       = -100;
        repeat (2) @(negedge clk);
        check_eq("rst_scl", 32'(scl0), 32'd1);
        check_eq("rst_sda", 32'(sda_out0), 32'd1);
        check_eq("rst_finish", 32'(fin0), 32'd0);
        check_eq("rst_ack", 32'(ack0), 32'd0);
        check_eq("rst_error", 32'(err0), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // A5 with slave ACK
        test_id = 1;
        ack_en  = 1'b1;
        run_full(8'hA5, 1'b1);
        end_byte();
        ack_en  = 1'b0;

        // 3C with NACK
        test_id = 2;
        run_full(8'h3C, 1'b0);
        end_byte();

        // FF, bus held low during bit 2 high phase: lost arbitration
        test_id = 3;
        start_byte(8'hFF);
        while (n < 24) begin
            step();
            if (n == 23) check_eq("arb_finish_early", 32'(fin0), 32'd0);
        end
        check_eq("arb_finish", 32'(fin0), 32'd1);
        check_eq("arb_error", 32'(err0), 32'd1);
        check_eq("arb_sda_release", 32'(sda_out0), 32'd1);
        check_eq("arb_nochk_error", 32'(err1), 32'd0);
        repeat (6) step();
        check_eq("arb_sda_held", 32'(sda_out0), 32'd1);
        check_eq("arb_finish_held", 32'(fin0), 32'd1);
        go = 1'b0;
        step();
        check_eq("arb_idle_finish", 32'(fin0), 32'd0);
        check_eq("arb_idle_error_kept", 32'(err0), 32'd1);

        // 00 with a one-sample glitch at bit 4 phase 6
        test_id = 4;
        start_byte(8'h00);
        while (n < 40) begin
            step();
            if (n == 39) check_eq("glitch_error_early", 32'(err0), 32'd0);
        end
        check_eq("glitch_error", 32'(err0), 32'd1);
        check_eq("glitch_finish", 32'(fin0), 32'd1);
        check_eq("glitch_nochk_error", 32'(err1), 32'd1);
        check_eq("glitch_nochk_finish", 32'(fin1), 32'd1);
        go = 1'b0;
        step();

        // abort at bit 3 phase 2, restart with 81
        test_id = 5;
        start_byte(8'h42);
        while (n < 26) step();
        check_eq("pre_abort_sda", 32'(sda_out0), 32'd0);
        go = 1'b0;
        step();
        check_eq("abort_scl", 32'(scl0), 32'd1);
        check_eq("abort_sda", 32'(sda_out0), 32'd1);
        check_eq("abort_finish", 32'(fin0), 32'd0);
        step();
        ack_en = 1'b1;
        run_full(8'h81, 1'b1);
        end_byte();
        ack_en = 1'b0;

        // asynchronous reset in the middle of bit 5
        test_id = 6;
        start_byte(8'h55);
        while (n < 44) step();
        check_eq("pre_reset_scl", 32'(scl0), 32'd0);
        #2;
        rst_n = 1'b0;
        go    = 1'b0;
        #1;
        check_eq("areset_scl", 32'(scl0), 32'd1);
        check_eq("areset_sda", 32'(sda_out0), 32'd1);
        check_eq("areset_finish", 32'(fin0), 32'd0);
        check_eq("areset_ack", 32'(ack0), 32'd0);
        check_eq("areset_error", 32'(err0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) step();
        check_eq("quiet_scl", 32'(scl0), 32'd1);
        check_eq("quiet_sda", 32'(sda_out0), 32'd1);
        check_eq("quiet_finish", 32'(fin0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_master_write_byte.md
# i2c_master_write_byte

I2C master transmit engine: serialises one byte MSB-first onto SDA, generates SCL for all 9 bit slots, then releases SDA for the acknowledge slot and samples the slave's ACK. It sits beside the master read-bit engine under the byte-level master controller, which sequences START/STOP and hands off one byte per `go` request. While SCL is high it checks each driven bit against the bus. A mismatch is reported as an error, covering both lost arbitration and a stuck bus.

## Interface
Parameters:
- CHECK_BUS, default 1: 1 = compare the sampled SDA against the driven SDA on data bits; 0 = skip the compare (ACK and stability checks remain).

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- go  in  1  level request; held high for the whole byte; low aborts or acknowledges completion
- data  in  8  byte to send, captured on the start edge
- finish  out  1  byte complete (or aborted on error); held while `go` stays high
- ack  out  1  1 = slave drove ACK (SDA low) in slot 9
- error  out  1  bus mismatch, unstable SDA, or lost arbitration
- sda_in  in  1  synchronised SDA line level
- sda_out  out  1  open-drain control: 0 = pull low, 1 = release
- scl  out  1  SCL drive level

## Operation
- All outputs are registered. One clock domain. Reset is asynchronous, active-low.
- Reset values: scl=1, sda_out=1, finish=0, ack=0, error=0, state IDLE, phase=0, bit index=0.
- States:
  - IDLE: scl=1, sda_out=1.
    - go=1 → capture `data` into the shift register, clear ack/error, enter SHIFT at bit 0, phase 0.
  - SHIFT (bits 0–7, MSB first): 8 phases per bit. Last phase of bit 7 → ACK.
  - ACK (bit 8): sda_out=1 (released). Last phase → DONE.
  - DONE: finish=1; scl=1; sda_out held at the ACK-slot value of 1.
    - Stays in DONE while go=1.
    - go=0 → IDLE.
- Phase counter: 3-bit, wraps 7→0 and advances the bit index.
  - Phases 0–3: scl=0.
  - Phases 4–7: scl=1.
  - sda_out is updated to the current bit on phase 1, never while scl=1.
- Sampling: sda_in is sampled at phases 5, 6 and 7, giving 3 samples.
  - All 1 → bit value 1.
  - All 0 → bit value 0.
  - Mixed → unstable → error.
- Data-bit check (CHECK_BUS=1):
  - A sampled value that differs from the driven bit sets error.
  - Driven 1 but read 0 = lost arbitration.
  - Driven 0 but read 1 = bus fault.
- On error in any slot: go to DONE at the phase-7 edge of that slot, with finish=1, error=1, sda_out=1.
- ACK slot:
  - Sampled 0 → ack=1.
  - Sampled 1 → ack=0, error=0 (a NACK is not an error).
  - Unstable → error=1, ack=0.
- go=0 in SHIFT or ACK: abort at the next edge → IDLE with scl=1, sda_out=1, finish=0. ack and error keep their last values.
- finish is cleared on the edge after go falls.
- A new byte requires go low for at least 1 cycle: no back-to-back rearm from DONE.

## Timing
- Start edge S is the edge where go=1 is seen in IDLE. Bit k, phase p is registered at edge S+1+8k+p.
- scl falls one cycle after S (the phase-0 register).
- sda_out is valid from the cycle after phase 1, at least 2 cycles before the scl rise.
- Full byte: finish rises at edge S+72 (ACK phase 7); ack and error are valid in the same cycle.
- Error abort in bit k: finish at edge S+8+8k.
- Mid-operation reset: all outputs return to reset values immediately; the bus is released.

## Structure
- Shared package `i2c_pkg`:
  - state encoding (IDLE, SHIFT, ACK, DONE)
  - PHASES_PER_BIT=8, SCL_HIGH_PHASE=4, SDA_UPDATE_PHASE=1, SAMPLE_FIRST_PHASE=5, BITS_PER_BYTE=8
  - sample-vote result codes
- Sub-module `i2c_bit_sampler`:
  - 3-sample vote with clear/enable inputs.
  - Outputs: value, unstable.
  - Reusable by the read-bit path.

## Test plan
- data=8'hA5, slave ACKs (sda_in follows sda_out, 0 in slot 9) → sda_out sequence 1,0,1,0,0,1,0,1; finish at S+72; ack=1, error=0.
- data=8'h3C, sda_in=1 throughout slot 9 → finish at S+72; ack=0, error=0.
- data=8'hFF, sda_in forced 0 during bit 2 high phase → error=1 and finish=1 at S+24; sda_out=1 from then on.
- data=8'h00, sda_in glitches to 1 only at phase 6 of bit 4 → error=1 at S+40; with CHECK_BUS=0 the same glitch still errors (unstable).
- go dropped at bit 3 phase 2, then reasserted 2 cycles later with data=8'h81 → IDLE with scl=1, sda_out=1; fresh byte completes 72 cycles after the new start with ack per stimulus.
- reset_n pulsed low mid-bit 5 → scl=1, sda_out=1, finish=0, ack=0, error=0 asynchronously; no activity until the next go.
